// File: rtl/byte_serial_pkg.sv
// Shared definitions for the byte-serial transmitter: state encoding,
// line idle level and a frame-length helper.
package byte_serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic LINE_IDLE = 1'b1;

  // Total clk cycles occupied by one frame on the wire.
  function automatic int frame_len(input int clks_per_bit, input int data_w,
                                   input int parity_en, input int stop_bits);
    return (1 + data_w + parity_en + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each serial bit. Held at zero while clear is asserted.
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: restart on clear or after the last cycle of a bit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = (cnt_q == CNT_LAST);

endmodule

// File: rtl/byte_serial_tx.sv
// Byte-to-serial transmitter: accepts a byte on valid/ready and sends it as
// start bit, data LSB first, optional even parity, then stop bit(s).
// txd/txd_oe/busy are registered; tx_ready is decoded from state so a new
// byte can be taken in the very last stop cycle for gap-free streaming.
module byte_serial_tx
  import byte_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              txd,
  output logic              txd_oe,
  output logic              busy
);

  localparam logic [2:0] DATA_LAST = 3'(DATA_W - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  tx_state_e         state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              txd_q, txd_d;
  logic              oe_q, oe_d;
  logic              busy_q, busy_d;
  logic              bit_end;
  logic              last_stop;
  logic              accept;

  serial_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == ST_IDLE),
    .bit_end(bit_end)
  );

  assign last_stop = (state_q == ST_STOP) && (idx_q == STOP_LAST) && bit_end;
  assign tx_ready  = (state_q == ST_IDLE) || last_stop;
  assign accept    = tx_valid && tx_ready;

  // Frame sequencing: state, bit index, shift register and parity.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_START;
          shift_d = tx_data;
          par_d   = ^tx_data;
          idx_d   = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = 3'd0;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end && (idx_q == DATA_LAST)) begin
          state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          idx_d   = 3'd0;
        end else if (bit_end) begin
          idx_d   = idx_q + 3'd1;
          shift_d = {1'b0, shift_q[DATA_W-1:1]};
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          idx_d   = 3'd0;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (last_stop && accept) begin
          state_d = ST_START;
          shift_d = tx_data;
          par_d   = ^tx_data;
          idx_d   = 3'd0;
        end else if (last_stop) begin
          state_d = ST_IDLE;
          idx_d   = 3'd0;
        end else if (bit_end) begin
          idx_d   = idx_q + 3'd1;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  // Line outputs derived from the next state so they change on the edge.
  always_comb begin
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
      ST_PARITY: txd_d = par_d;
      ST_STOP:   txd_d = 1'b1;
      default:   txd_d = LINE_IDLE;
    endcase
    oe_d   = (state_d != ST_IDLE);
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset returns the line to idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= LINE_IDLE;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
    end
  end

  assign txd    = txd_q;
  assign txd_oe = oe_q;
  assign busy   = busy_q;

endmodule
